// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: owner encoding and FSM state type.
package dmem_arb_pkg;

    localparam logic [1:0] OWNER_NONE   = 2'd0;
    localparam logic [1:0] OWNER_CORE   = 2'd1;
    localparam logic [1:0] OWNER_LOADER = 2'd2;

    // The state records who owned the memory port in the previous cycle.
    typedef enum logic [1:0] {
        IDLE   = OWNER_NONE,
        CORE   = OWNER_CORE,
        LOADER = OWNER_LOADER
    } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core, the loader, the arbiter and the SRAM macro.
// slave: the arbiter's view; master: the requesters'/memory's view.
interface dmem_arbiter_if #(parameter int ADDR_WIDTH = 13);
    logic                  c_req_i;
    logic                  c_web_i;
    logic [ADDR_WIDTH-1:0] c_addr_i;
    logic [31:0]           c_wdata_i;
    logic [3:0]            c_wmask_i;
    logic                  c_gnt_o;
    logic [31:0]           c_rdata_o;
    logic                  c_rvalid_o;

    logic                  l_req_i;
    logic                  l_web_i;
    logic [ADDR_WIDTH-1:0] l_addr_i;
    logic [31:0]           l_wdata_i;
    logic [3:0]            l_wmask_i;
    logic                  l_lock_i;
    logic                  l_gnt_o;
    logic [31:0]           l_rdata_o;
    logic                  l_rvalid_o;

    logic                  mem_csb_o;
    logic                  mem_web_o;
    logic [3:0]            mem_wmask_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [31:0]           mem_din_o;
    logic [31:0]           mem_dout_i;

    modport slave (
        input  c_req_i, c_web_i, c_addr_i, c_wdata_i, c_wmask_i,
        input  l_req_i, l_web_i, l_addr_i, l_wdata_i, l_wmask_i, l_lock_i,
        input  mem_dout_i,
        output c_gnt_o, c_rdata_o, c_rvalid_o,
        output l_gnt_o, l_rdata_o, l_rvalid_o,
        output mem_csb_o, mem_web_o, mem_wmask_o, mem_addr_o, mem_din_o
    );

    modport master (
        output c_req_i, c_web_i, c_addr_i, c_wdata_i, c_wmask_i,
        output l_req_i, l_web_i, l_addr_i, l_wdata_i, l_wmask_i, l_lock_i,
        output mem_dout_i,
        input  c_gnt_o, c_rdata_o, c_rvalid_o,
        input  l_gnt_o, l_rdata_o, l_rvalid_o,
        input  mem_csb_o, mem_web_o, mem_wmask_o, mem_addr_o, mem_din_o
    );
endinterface

// File: rtl/dmem_arb_starve_cnt.sv
// Counts consecutive cycles the loader has waited; saturates at LIMIT.
module dmem_arb_starve_cnt #(
    parameter int LIMIT = 8
) (
    input  logic clk_i,
    input  logic reset,
    input  logic waiting,   // "wait" is a reserved word
    input  logic clear,
    output logic at_limit
);
    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt;

    // Saturating wait counter; clear wins over increment.
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (waiting && (cnt != LIM)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt == LIM);
endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter (core, loader) for a single-port data SRAM.
// Optional loader anti-starvation counter enabled by macro DMEM_ARB_STARVE_EN;
// without it the core has strict priority except while the loader holds a lock.
//
// state  | meaning
// IDLE   | no access granted last cycle
// CORE   | core owned the port last cycle
// LOADER | loader owned the port last cycle (lock may extend ownership)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 13,
    parameter int STARVE_LIMIT = 8
) (
    input  logic           clk_i,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("STARVE_LIMIT must be at least 1");
    end

    arb_state_t            state;
    logic                  c_gnt;
    logic                  l_gnt;
    logic                  lock_hold;
    logic                  starved;
    logic                  l_first;
    logic                  c_rvalid;
    logic                  l_rvalid;
    logic                  mem_csb;
    logic                  mem_web;
    logic [3:0]            mem_wmask;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_din;

`ifdef DMEM_ARB_STARVE_EN
    dmem_arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve_cnt (
        .clk_i    (clk_i),
        .reset    (reset),
        .waiting  (bus.l_req_i && !l_gnt),
        .clear    (l_gnt || !bus.l_req_i),
        .at_limit (starved)
    );
`else
    assign starved = 1'b0;
`endif

    // Grant decision; reset gating keeps the memory idle while reset is held.
    always_comb begin
        lock_hold = (state == LOADER) && bus.l_lock_i && bus.l_req_i;
        l_first   = lock_hold || (starved && bus.l_req_i);
        c_gnt     = reset && !l_first && bus.c_req_i;
        l_gnt     = reset && bus.l_req_i && (l_first || !bus.c_req_i);
    end

    // Steer the granted requester onto the memory pins, idle values otherwise.
    always_comb begin
        mem_csb   = 1'b1;
        mem_web   = 1'b1;
        mem_wmask = 4'h0;
        mem_addr  = '0;
        mem_din   = 32'h0;
        if (c_gnt) begin
            mem_csb   = 1'b0;
            mem_web   = bus.c_web_i;
            mem_wmask = bus.c_wmask_i;
            mem_addr  = bus.c_addr_i;
            mem_din   = bus.c_wdata_i;
        end else if (l_gnt) begin
            mem_csb   = 1'b0;
            mem_web   = bus.l_web_i;
            mem_wmask = bus.l_wmask_i;
            mem_addr  = bus.l_addr_i;
            mem_din   = bus.l_wdata_i;
        end
    end

    // Owner FSM plus read-valid pulses one cycle after a granted read.
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            c_rvalid <= 1'b0;
            l_rvalid <= 1'b0;
        end else begin
            if (c_gnt) begin
                state <= CORE;
            end else if (l_gnt) begin
                state <= LOADER;
            end else begin
                state <= IDLE;
            end
            c_rvalid <= c_gnt && bus.c_web_i;
            l_rvalid <= l_gnt && bus.l_web_i;
        end
    end

    assign bus.c_gnt_o     = c_gnt;
    assign bus.l_gnt_o     = l_gnt;
    assign bus.c_rvalid_o  = c_rvalid;
    assign bus.l_rvalid_o  = l_rvalid;
    assign bus.c_rdata_o   = bus.mem_dout_i;
    assign bus.l_rdata_o   = bus.mem_dout_i;
    assign bus.mem_csb_o   = mem_csb;
    assign bus.mem_web_o   = mem_web;
    assign bus.mem_wmask_o = mem_wmask;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_din_o   = mem_din;
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 13, the memory word-address width.
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 8, the maximum number of consecutive cycles the loader waits while requesting.
REQ-003 The block SHALL have these ports:
- clk_i  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- c_req_i  in  1  core access request
- c_web_i  in  1  core write enable, active-low
- c_addr_i  in  ADDR_WIDTH  core word address
- c_wdata_i  in  32  core write data
- c_wmask_i  in  4  core byte mask
- c_gnt_o  out  1  core granted this cycle
- c_rdata_o  out  32  core read data
- c_rvalid_o  out  1  core read data valid
- l_req_i, l_web_i, l_addr_i, l_wdata_i, l_wmask_i  in  as core  loader request set
- l_lock_i  in  1  loader holds ownership for a burst
- l_gnt_o, l_rdata_o, l_rvalid_o  out  as core  loader responses
- mem_csb_o  out  1  memory chip select, active-low
- mem_web_o  out  1  memory write enable, active-low
- mem_wmask_o  out  4  memory byte mask
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_din_o  out  32  memory write data
- mem_dout_i  in  32  memory read data, one cycle after the address edge

Function
REQ-004 Grant SHALL be combinational from the current inputs and state; at most one of c_gnt_o and l_gnt_o SHALL be high in any cycle.
REQ-005 When a requester is granted, the mem_* outputs SHALL carry that requester's web, addr, wdata and wmask, and mem_csb_o SHALL be 0.
REQ-006 With no grant: mem_csb_o=1, mem_web_o=1, mem_wmask_o=0, mem_addr_o=0, mem_din_o=0.
REQ-007 The FSM SHALL have states IDLE, CORE and LOADER, recording the owner of the previous cycle's access; it SHALL go to CORE on c_gnt_o, to LOADER on l_gnt_o, and otherwise to IDLE.
REQ-008 Priority order: (1) loader, if the state is LOADER and l_lock_i=1 and l_req_i=1; (2) loader, if the starve counter equals STARVE_LIMIT; (3) core, if c_req_i=1; (4) loader, if l_req_i=1.
REQ-009 The starve counter SHALL increment each cycle that l_req_i=1 and l_gnt_o=0, saturating at STARVE_LIMIT; it SHALL clear on l_gnt_o or when l_req_i=0.
REQ-010 l_lock_i SHALL be ignored unless the state is LOADER; lock with l_req_i=0 SHALL release ownership.
REQ-011 c_rvalid_o/l_rvalid_o SHALL pulse exactly one cycle after a granted read (web=1) by that requester; granted writes SHALL produce no rvalid.
REQ-012 c_rdata_o and l_rdata_o SHALL both be driven from mem_dout_i and are valid only with the matching rvalid.
REQ-013 An ungranted requester SHALL hold its request fields stable until granted; the block does not queue.
REQ-014 Back-to-back grants to alternating requesters SHALL be allowed on consecutive cycles, with no bubble.

Reset
REQ-015 On reset=0, asynchronously: state=IDLE, starve counter=0, c_rvalid_o=0, l_rvalid_o=0; a read-valid pending across reset SHALL be dropped.
REQ-016 While reset=0, c_gnt_o=0, l_gnt_o=0, and the mem_* outputs SHALL be at their REQ-006 values.

Configuration
REQ-017 With macro DMEM_ARB_STARVE_EN defined, the starve counter and priority rule (2) SHALL be present.
REQ-018 Without DMEM_ARB_STARVE_EN, no counter logic SHALL exist, rule (2) SHALL be removed, and the core SHALL have strict priority apart from the lock.

Structure
REQ-019 Package dmem_arb_pkg SHALL hold the FSM state enum (IDLE, CORE, LOADER) and the owner encoding constants.
REQ-020 The starve counter SHALL be the sub-module dmem_arb_starve_cnt, with inputs wait and clear and output at_limit, instantiated only under DMEM_ARB_STARVE_EN.

Verification
REQ-021 Core read at 0x010 alone -> c_gnt_o=1 in the same cycle, mem_addr_o=0x010, mem_csb_o=0; c_rvalid_o=1 in the next cycle with data from the memory model.
REQ-022 Both request every cycle, STARVE_EN on, STARVE_LIMIT=8 -> core is granted 8 cycles, then loader is granted on the 9th cycle, and the counter returns to 0.
REQ-023 Loader write with l_lock_i=1 for 4 cycles while the core requests -> loader is granted 4 consecutive cycles, then the core is granted, and no l_rvalid_o is produced.
REQ-024 Reset asserted in the cycle after a granted core read -> c_rvalid_o stays 0, all gnt outputs are 0, and mem_csb_o=1.
REQ-025 STARVE_EN undefined, both requesting for 20 cycles -> loader is never granted.
